// File: rtl/rx_slicer_ber.sv
// rx_slicer_ber: 16-QAM receive decimator, slicer and windowed symbol/|error| meter.
module rx_slicer_ber #(
  parameter int DLY_W = 4,
  parameter int CNT_W = 16,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    sam_en,
  input  logic                    sym_en,
  input  logic [1:0]              phase_sel,
  input  logic signed [17:0]      in_phs_sig,
  input  logic signed [17:0]      quad_sig,
  input  logic [17:0]             ref_level,
  input  logic [3:0]              ref_sym,
  input  logic [DLY_W-1:0]        ref_delay,
  input  logic                    start,
  input  logic [CNT_W-1:0]        win_len,
  output logic [3:0]              sym_out,
  output logic                    sym_valid,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_W-1:0]        err_count,
  output logic [ACC_W-1:0]        abs_err
);

  localparam int DEPTH = 1 << DLY_W;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MEAS = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Per-axis decision against +/-2A; ties go to the upper region.
  function automatic logic [1:0] slice_ax(input logic signed [17:0] x,
                                          input logic [17:0] a);
    logic signed [19:0] xs;
    logic signed [19:0] thr;
    xs  = {{2{x[17]}}, x};
    thr = {1'b0, a, 1'b0};
    if (xs >= thr)
      slice_ax = 2'b10;
    else if (xs >= 20'sd0)
      slice_ax = 2'b11;
    else if (xs >= -thr)
      slice_ax = 2'b01;
    else
      slice_ax = 2'b00;
  endfunction

  // Ideal constellation level for a sliced axis code.
  function automatic logic signed [20:0] ideal_lvl(input logic [1:0] code,
                                                   input logic [17:0] a);
    logic signed [20:0] a1;
    logic signed [20:0] a3;
    a1 = {3'b000, a};
    a3 = a1 + (a1 <<< 1);
    case (code)
      2'b10:   ideal_lvl = a3;
      2'b11:   ideal_lvl = a1;
      2'b01:   ideal_lvl = -a1;
      default: ideal_lvl = -a3;
    endcase
  endfunction

  // |x - level|, clipped to the 19-bit error term range.
  function automatic logic [18:0] sat_abs19(input logic signed [17:0] x,
                                            input logic signed [20:0] lvl);
    logic signed [20:0] d;
    logic [20:0]        m;
    d = {{3{x[17]}}, x} - lvl;
    m = d[20] ? -d : d;
    sat_abs19 = (m > 21'h07FFFF) ? 19'h7FFFF : m[18:0];
  endfunction

  // Accumulator add that sticks at all-ones instead of wrapping.
  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                               input logic [19:0] term);
    logic [ACC_W:0] s;
    s = {1'b0, acc} + (ACC_W+1)'(term);
    sat_acc = s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  logic [1:0]         ph_q;
  logic [1:0]         ph_cur;
  logic               take;
  logic signed [17:0] i_p0;
  logic signed [17:0] q_p0;
  logic               vld_p0;
  logic [1:0]         si_p0;
  logic [1:0]         sq_p0;
  logic [19:0]        term_p0;
  logic [19:0]        term_p1;
  logic [3:0]         dly_mem [DEPTH];
  logic [DLY_W-1:0]   wr_ptr;
  logic [DLY_W-1:0]   rd_idx;
  logic [3:0]         ref_al;
  state_t             state_q;
  state_t             state_d;
  logic               clr;
  logic               acc_en;
  logic [CNT_W-1:0]   sym_cnt;
  logic [CNT_W-1:0]   win_q;

  // Phase of the sample currently presented: 0 on a symbol boundary, else last + 1.
  assign ph_cur = sym_en ? 2'd0 : ph_q + 2'd1;
  assign take   = sam_en && (ph_cur == phase_sel);

  // Sample-phase counter, advanced only by sample enables.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ph_q <= 2'd0;
    else if (sam_en)
      ph_q <= ph_cur;
  end

  // Stage p0: decimation, hold the selected I/Q pair.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0 <= 1'b0;
      i_p0   <= '0;
      q_p0   <= '0;
    end else begin
      vld_p0 <= take;
      if (take) begin
        i_p0 <= in_phs_sig;
        q_p0 <= quad_sig;
      end
    end
  end

  // Slice the captured pair and form the combined |error| term.
  always_comb begin
    si_p0   = slice_ax(i_p0, ref_level);
    sq_p0   = slice_ax(q_p0, ref_level);
    term_p0 = {1'b0, sat_abs19(i_p0, ideal_lvl(si_p0, ref_level))}
            + {1'b0, sat_abs19(q_p0, ideal_lvl(sq_p0, ref_level))};
  end

  // Stage p1: publish the sliced symbol, its strobe and error term.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_valid <= 1'b0;
      sym_out   <= 4'd0;
      term_p1   <= 20'd0;
    end else begin
      sym_valid <= vld_p0;
      if (vld_p0) begin
        sym_out <= {si_p0, sq_p0};
        term_p1 <= term_p0;
      end
    end
  end

  // Reference delay line: one write per symbol enable, circular pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      for (int k = 0; k < DEPTH; k++)
        dly_mem[k] <= 4'd0;
    end else if (sym_en) begin
      dly_mem[wr_ptr] <= ref_sym;
      wr_ptr          <= wr_ptr + DLY_W'(1);
    end
  end

  // Same-cycle writes land at the clock edge, so the compare sees the older contents.
  assign rd_idx = wr_ptr - DLY_W'(1) - ref_delay;
  assign ref_al = dly_mem[rd_idx];

  // Measurement FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state, window clear/accumulate controls and status outputs.
  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    acc_en  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_MEAS;
          clr     = 1'b1;
        end
      end
      S_MEAS: begin
        busy = 1'b1;
        if (sym_cnt == win_q)
          state_d = S_DONE;
        else if (sym_valid)
          acc_en = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          state_d = S_MEAS;
          clr     = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Window counters: cleared on an accepted start, frozen outside MEASURE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sym_cnt   <= '0;
      win_q     <= '0;
      err_count <= '0;
      abs_err   <= '0;
    end else if (clr) begin
      sym_cnt   <= '0;
      win_q     <= win_len;
      err_count <= '0;
      abs_err   <= '0;
    end else if (acc_en) begin
      sym_cnt   <= sym_cnt + CNT_W'(1);
      err_count <= err_count + CNT_W'(sym_out != ref_al);
      abs_err   <= sat_acc(abs_err, term_p1);
    end
  end

endmodule

// File: tb/tb_rx_slicer_ber.sv
// tb_rx_slicer_ber: table vectors, directed control sequences and randomized
// windows compared against a symbol-level reference model.
`timescale 1ns/1ps
module tb_rx_slicer_ber;
  localparam int DLY_W = 4;
  localparam int CNT_W = 16;
  localparam int ACC_W = 32;

  logic               clk;
  logic               reset;
  logic               sam_en;
  logic               sym_en;
  logic [1:0]         phase_sel;
  logic signed [17:0] in_phs_sig;
  logic signed [17:0] quad_sig;
  logic [17:0]        ref_level;
  logic [3:0]         ref_sym;
  logic [DLY_W-1:0]   ref_delay;
  logic               start;
  logic [CNT_W-1:0]   win_len;
  logic [3:0]         sym_out;
  logic               sym_valid;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   err_count;
  logic [ACC_W-1:0]   abs_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  rx_slicer_ber #(.DLY_W(DLY_W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .sam_en(sam_en), .sym_en(sym_en),
    .phase_sel(phase_sel), .in_phs_sig(in_phs_sig), .quad_sig(quad_sig),
    .ref_level(ref_level), .ref_sym(ref_sym), .ref_delay(ref_delay),
    .start(start), .win_len(win_len), .sym_out(sym_out), .sym_valid(sym_valid),
    .busy(busy), .done(done), .err_count(err_count), .abs_err(abs_err)
  );

  typedef struct { logic signed [17:0] i; logic signed [17:0] q; logic [3:0] sym; } vec_t;
  typedef struct { int due; logic [3:0] sym; int term; } exp_t;

  vec_t       tbl [22];
  exp_t       exp_q [$];
  logic [3:0] hist [4096];
  logic [3:0] sl [103];
  logic signed [17:0] pi [103];
  logic signed [17:0] pq [103];
  int     nwr, cyc, cur_phase, vectors, miscompares;
  bit     m_active;
  int     m_cnt, m_win, m_err;
  longint m_abs;

  // Reference slicer: region code of x for inner level a.
  function automatic int ax_bits(int x, int a);
    if (x >= 2 * a) return 2;
    if (x >= 0) return 3;
    if (x >= -2 * a) return 1;
    return 0;
  endfunction

  function automatic int ax_err(int x, int a);
    int lv, d;
    case (ax_bits(x, a))
      2: lv = 3 * a;
      3: lv = a;
      1: lv = -a;
      default: lv = -3 * a;
    endcase
    d = x - lv;
    if (d < 0) d = -d;
    if (d > 'h7FFFF) d = 'h7FFFF;
    return d;
  endfunction

  function automatic logic [3:0] m_sym(int x, int y, int a);
    int bx, by;
    bx = ax_bits(x, a);
    by = ax_bits(y, a);
    return {bx[1:0], by[1:0]};
  endfunction

  // Constellation point for axis index 0..3 at A = 0x8000: -3A, -A, +A, +3A.
  function automatic logic signed [17:0] pt(int idx);
    case (idx & 3)
      0: return 18'h28000;
      1: return 18'h38000;
      2: return 18'h08000;
      default: return 18'h18000;
    endcase
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // One clock: account for what the last edge consumed, then check the strobe.
  task automatic tick();
    exp_t       e;
    int         ridx;
    logic [3:0] rs;
    @(negedge clk);
    cyc++;
    if (reset && sym_en) begin
      if (nwr < 4096) hist[nwr] = ref_sym;
      nwr++;
    end
    if (m_active && m_cnt >= m_win) m_active = 0;
    if (reset && start && !m_active) begin
      m_active = 1; m_cnt = 0; m_err = 0; m_abs = 0; m_win = int'(win_len);
    end
    if (sym_valid) begin
      if (exp_q.size() == 0) begin
        check("strobe_expected", longint'(exp_q.size()), 1);
      end else begin
        e = exp_q.pop_front();
        check("strobe_time", longint'(cyc), longint'(e.due));
        check("sym_out", longint'(sym_out), longint'(e.sym));
        ridx = nwr - 1 - int'(ref_delay);
        rs = (ridx >= 0 && ridx < 4096) ? hist[ridx] : 4'd0;
        if (m_active && m_cnt < m_win) begin
          m_cnt++;
          if (e.sym != rs) m_err++;
          m_abs += longint'(e.term);
          if (m_abs > 64'hFFFFFFFF) m_abs = 64'hFFFFFFFF;
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      check("sym_valid", longint'(sym_valid), 1);
      void'(exp_q.pop_front());
    end
    if (reset && sam_en && cur_phase == int'(phase_sel)) begin
      e.due  = cyc + 1;
      e.sym  = m_sym(int'(in_phs_sig), int'(quad_sig), int'(ref_level));
      e.term = ax_err(int'(in_phs_sig), int'(ref_level)) + ax_err(int'(quad_sig), int'(ref_level));
      exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    sam_en = 0; sym_en = 0; start = 0;
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic pulse_start(input int w);
    sam_en = 0; sym_en = 0; start = 1; win_len = CNT_W'(w);
    tick();
    start = 0;
  endtask

  // Four samples of one symbol; phase vph carries (iv,qv), the rest are random.
  task automatic send_sym(input logic signed [17:0] iv, input logic signed [17:0] qv,
                          input int vph, input logic [3:0] rs);
    for (int p = 0; p < 4; p++) begin
      sam_en = 1; sym_en = (p == 0); ref_sym = rs; cur_phase = p;
      if (p == vph) begin
        in_phs_sig = iv; quad_sig = qv;
      end else begin
        in_phs_sig = 18'($urandom); quad_sig = 18'($urandom);
      end
      tick();
    end
    sam_en = 0; sym_en = 0;
  endtask

  task automatic check_window(input string tag);
    idle(8);
    check({tag, "_done"}, longint'(done), 1);
    check({tag, "_busy"}, longint'(busy), 0);
    check({tag, "_err_count"}, longint'(err_count), longint'(m_err));
    check({tag, "_abs_err"}, longint'(abs_err), m_abs);
  endtask

  // Random valid points on the A = 0x8000 grid; sl holds their reference symbols.
  task automatic gen_points();
    for (int s = 0; s < 103; s++) begin
      pi[s] = pt(int'($urandom_range(0, 3)));
      pq[s] = pt(int'($urandom_range(0, 3)));
      sl[s] = m_sym(int'(pi[s]), int'(pq[s]), 'h8000);
    end
  endtask

  // Preamble of 3 symbols, then a 100-symbol window whose ref leads by 3 symbols.
  task automatic align_run(input int dly);
    gen_points();
    ref_delay = DLY_W'(dly);
    for (int s = 0; s < 3; s++) send_sym(pi[s], pq[s], 0, sl[s]);
    idle(4);
    pulse_start(100);
    for (int s = 0; s < 100; s++) send_sym(pi[s], pq[s], 0, sl[s + 3]);
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; nwr = 0; cur_phase = 0;
    m_active = 0; m_cnt = 0; m_win = 0; m_err = 0; m_abs = 0;
    reset = 0; sam_en = 0; sym_en = 0; phase_sel = 0; in_phs_sig = 0; quad_sig = 0;
    ref_level = 18'h08000; ref_sym = 0; ref_delay = 0; start = 0; win_len = 0;

    tbl[0]  = '{18'h28000, 18'h28000, 4'h0};  tbl[1]  = '{18'h28000, 18'h38000, 4'h1};
    tbl[2]  = '{18'h28000, 18'h08000, 4'h3};  tbl[3]  = '{18'h28000, 18'h18000, 4'h2};
    tbl[4]  = '{18'h38000, 18'h28000, 4'h4};  tbl[5]  = '{18'h38000, 18'h38000, 4'h5};
    tbl[6]  = '{18'h38000, 18'h08000, 4'h7};  tbl[7]  = '{18'h38000, 18'h18000, 4'h6};
    tbl[8]  = '{18'h08000, 18'h28000, 4'hC};  tbl[9]  = '{18'h08000, 18'h38000, 4'hD};
    tbl[10] = '{18'h08000, 18'h08000, 4'hF};  tbl[11] = '{18'h08000, 18'h18000, 4'hE};
    tbl[12] = '{18'h18000, 18'h28000, 4'h8};  tbl[13] = '{18'h18000, 18'h38000, 4'h9};
    tbl[14] = '{18'h18000, 18'h08000, 4'hB};  tbl[15] = '{18'h18000, 18'h18000, 4'hA};
    tbl[16] = '{18'h10000, 18'h08000, 4'hB};  tbl[17] = '{18'h0FFFF, 18'h08000, 4'hF};
    tbl[18] = '{18'h00000, 18'h08000, 4'hF};  tbl[19] = '{18'h3FFFF, 18'h08000, 4'h7};
    tbl[20] = '{18'h30000, 18'h08000, 4'h7};  tbl[21] = '{18'h2FFFF, 18'h08000, 4'h3};

    // Reset state
    tick(); tick();
    check("rst_sym_out", longint'(sym_out), 0);
    check("rst_sym_valid", longint'(sym_valid), 0);
    check("rst_busy", longint'(busy), 0);
    check("rst_done", longint'(done), 0);
    check("rst_err_count", longint'(err_count), 0);
    check("rst_abs_err", longint'(abs_err), 0);
    reset = 1;
    idle(2);

    // Ideal constellation, then threshold points
    pulse_start(16);
    for (int n = 0; n < 16; n++) begin
      send_sym(tbl[n].i, tbl[n].q, 0, tbl[n].sym);
      check("tbl_sym", longint'(sym_out), longint'(tbl[n].sym));
    end
    check_window("ideal");
    check("ideal_err_zero", longint'(err_count), 0);
    check("ideal_abs_zero", longint'(abs_err), 0);
    for (int n = 16; n < 22; n++) begin
      send_sym(tbl[n].i, tbl[n].q, 0, 4'h0);
      check("thr_sym", longint'(sym_out), longint'(tbl[n].sym));
    end
    idle(4);

    // Phase select: valid point only at phase 2
    gen_points();
    phase_sel = 2;
    pulse_start(20);
    for (int s = 0; s < 20; s++) send_sym(pi[s], pq[s], 2, sl[s]);
    check_window("phase2");
    check("phase2_err_zero", longint'(err_count), 0);
    phase_sel = 1;
    pulse_start(20);
    for (int s = 0; s < 20; s++) send_sym(pi[s], pq[s], 2, sl[s]);
    check_window("phase1");
    check("phase1_has_err", longint'(err_count != 0), 1);
    phase_sel = 0;

    // Alignment through the delay line, long enough to wrap the pointer
    align_run(3);
    check_window("align3");
    check("align3_err_zero", longint'(err_count), 0);
    align_run(2);
    check_window("align2");
    check("align2_has_err", longint'(err_count != 0), 1);

    // Constant offset noise
    ref_delay = 0;
    pulse_start(10);
    for (int s = 0; s < 10; s++) begin
      send_sym(pt(s) + 18'sh01000, pt(s + 2) + 18'sh01000, 0,
               m_sym(int'(pt(s)), int'(pt(s + 2)), 'h8000));
    end
    check_window("noise");
    check("noise_err_zero", longint'(err_count), 0);
    check("noise_abs", longint'(abs_err), 'h14000);

    // Start during MEASURE is ignored; results then freeze in DONE
    gen_points();
    pulse_start(8);
    for (int s = 0; s < 3; s++) send_sym(pi[s], pq[s], 0, ~sl[s]);
    pulse_start(2);
    check("ignored_start_busy", longint'(busy), 1);
    for (int s = 3; s < 8; s++) send_sym(pi[s], pq[s], 0, sl[s]);
    check_window("ignore");
    check("ignore_err", longint'(err_count), 3);
    for (int s = 8; s < 12; s++) send_sym(pi[s], pq[s], 0, ~sl[s]);
    idle(4);
    check("frozen_done", longint'(done), 1);
    check("frozen_err", longint'(err_count), 3);

    // Zero-length window
    pulse_start(0);
    check("win0_busy", longint'(busy), 1);
    tick();
    check("win0_done", longint'(done), 1);
    check("win0_err", longint'(err_count), 0);
    check("win0_abs", longint'(abs_err), 0);

    // Reset in the middle of a window
    pulse_start(20);
    for (int s = 0; s < 5; s++) send_sym(pi[s], pq[s], 0, ~sl[s]);
    idle(3);
    check("pre_rst_err", longint'(err_count), longint'(m_err));
    reset = 0;
    #1;
    check("mid_rst_sym_out", longint'(sym_out), 0);
    check("mid_rst_busy", longint'(busy), 0);
    check("mid_rst_done", longint'(done), 0);
    check("mid_rst_err", longint'(err_count), 0);
    check("mid_rst_abs", longint'(abs_err), 0);
    exp_q.delete(); nwr = 0; m_active = 0; m_cnt = 0; m_err = 0; m_abs = 0;
    tick();
    reset = 1;
    idle(2);
    check("post_rst_busy", longint'(busy), 0);
    check("post_rst_done", longint'(done), 0);
    ref_delay = 5;
    pulse_start(8);
    for (int s = 0; s < 8; s++) send_sym(pi[s], pq[s], 0, 4'($urandom));
    check_window("post_rst");

    // Randomized windows: random level, phase, delay, gaps and bare sym_en writes
    for (int r = 0; r < 4; r++) begin
      ref_level = 18'($urandom_range('h1000, 'h1FFFF));
      phase_sel = 2'($urandom);
      ref_delay = DLY_W'($urandom);
      idle(3);
      pulse_start(30);
      for (int s = 0; s < 34; s++) begin
        send_sym(18'($urandom), 18'($urandom), -1, 4'($urandom));
        if ($urandom_range(0, 3) == 0) begin
          sym_en = 1; ref_sym = 4'($urandom);
          tick();
          sym_en = 0;
        end
      end
      check_window("random");
    end

    idle(4);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
